// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: sequences one LEN-pair dot-product job through a shared MAC; optional STALL_TIMEOUT_EN aborts stalled jobs
module mac_dot_sequencer #(
    parameter int DW     = 4,
    parameter int ACCW   = 9,
    parameter int LENW   = 4,
    parameter int TO_CYC = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            len_err,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_b,
    output logic [DW-1:0]   mac_i,
    output logic [DW-1:0]   mac_j,
    output logic            mac_en,
    output logic            mac_clr,
    input  logic [ACCW-1:0] mac_f,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [ACCW-1:0] result,
    output logic            timeout
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [LENW-1:0] count;
    logic accept;
    logic stall_hit;
    assign accept = (state == RUN) && in_valid;
`ifdef STALL_TIMEOUT_EN
    localparam int TOW = $clog2(TO_CYC + 1);
    logic [TOW-1:0] idle_cnt;
    logic to_flag;
    assign stall_hit = (state == RUN) && !in_valid && (idle_cnt == TOW'(TO_CYC - 1));
    assign timeout = to_flag;
    // Stall counter runs only in RUN; the abort flag is sticky until the result is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            idle_cnt <= (state != RUN || accept) ? '0 : idle_cnt + 1'b1;
            if (stall_hit)
                to_flag <= 1'b1;
            else if (state == DONE && res_ready)
                to_flag <= 1'b0;
        end
    end
`else
    assign stall_hit = 1'b0;
    assign timeout = 1'b0;
`endif
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && len != '0) state_nx = CLEAR;
            CLEAR:   state_nx = RUN;
            RUN:     if ((accept && count == LENW'(1)) || stall_hit) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Outputs decoded from state; operands pass through only while streaming
    always_comb begin
        busy      = state != IDLE;
        in_ready  = state == RUN;
        mac_en    = accept;
        mac_clr   = state == CLEAR;
        mac_i     = (state == RUN) ? in_a : '0;
        mac_j     = (state == RUN) ? in_b : '0;
        res_valid = state == DONE;
    end
    // Pair counter, zero-length error pulse and result capture at the end of DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            len_err <= 1'b0;
            result  <= '0;
        end else begin
            len_err <= (state == IDLE) && start && (len == '0);
            if (state == IDLE && start && len != '0)
                count <= len;
            else if (accept)
                count <= count - 1'b1;
            if (state == DRAIN)
                result <= mac_f;
        end
    end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: scoreboard bench for mac_dot_sequencer with a behavioural MAC attached
module tb_mac_dot_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [3:0] len = '0;
    logic busy, len_err, in_ready, mac_en, mac_clr, res_valid, timeout;
    logic in_valid = 1'b0;
    logic [3:0] in_a = '0, in_b = '0, mac_i, mac_j;
    logic [8:0] mac_f = '0, result;
    logic res_ready = 1'b1;

    int checks = 0, errors = 0;
    int cyc = 0, last_acc = 0, en_n = 0, clr_n = 0, done_n = 0;
    logic rv_prev = 1'b0;
    logic [8:0] res_prev = '0;
    logic [9:0] exp_q[$];

    mac_dot_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .len_err(len_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_i(mac_i), .mac_j(mac_j), .mac_en(mac_en), .mac_clr(mac_clr), .mac_f(mac_f),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: clear wins over accumulate, wraps modulo 512, untouched by rst
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_clr) mac_f <= '0;
        else if (mac_en) mac_f <= mac_f + 9'(mac_i * mac_j);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each result handshake and watches result stability and latency
    always @(negedge clk) begin
        if (!rst) begin
            if (mac_en) begin en_n++; last_acc = cyc; end
            if (mac_clr) clr_n++;
            if (res_valid && !rv_prev && !timeout) chk("res_latency", cyc - last_acc, 2);
            if (res_valid && rv_prev) chk("res_stable", int'(result), int'(res_prev));
            if (res_valid && res_ready) begin
                done_n++;
                if (exp_q.size() == 0) chk("unexpected_result", int'(result), -1);
                else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    chk("result", int'(result), int'(e[8:0]));
                    chk("timeout", int'(timeout), int'(e[9]));
                end
            end
        end
        rv_prev = res_valid;
        res_prev = result;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic put(input logic [3:0] a, input logic [3:0] b);
        int n;
        in_valid = 1'b1; in_a = a; in_b = b; n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 50);
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 200);
        if (busy) chk("job_timeout", 0, 1);
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_mac_en"}, int'(mac_en), 0);
        chk({tag, "_mac_clr"}, int'(mac_clr), 0);
        chk({tag, "_mac_i"}, int'(mac_i), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        #2;
        check_zero("reset");
        chk("reset_result", int'(result), 0);
        chk("reset_len_err", int'(len_err), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Nominal job: 100+78+18+20 = 216
        en_n = 0; clr_n = 0;
        exp_q.push_back({1'b0, 9'd216});
        do_start(4'd4);
        put(4'd10, 4'd10); put(4'd13, 4'd6); put(4'd9, 4'd2); put(4'd5, 4'd4);
        wait_idle();
        chk("nominal_clr_cycles", clr_n, 1);
        chk("nominal_en_cycles", en_n, 4);

        // Wrap-around: 3*225 = 675 mod 512 = 163
        exp_q.push_back({1'b0, 9'd163});
        do_start(4'd3);
        put(4'd15, 4'd15); put(4'd15, 4'd15); put(4'd15, 4'd15);
        wait_idle();

        // Zero length
        clr_n = 0;
        start = 1'b1; len = 4'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("zero_len_err", int'(len_err), 1);
        chk("zero_busy", int'(busy), 0);
        @(negedge clk);
        chk("zero_len_err_drop", int'(len_err), 0);
        chk("zero_busy2", int'(busy), 0);
        chk("zero_clr", clr_n, 0);
        tick();

        // Backpressure on both sides: 9+4 = 13
        en_n = 0; clr_n = 0; done_n = 0;
        res_ready = 1'b0;
        exp_q.push_back({1'b0, 9'd13});
        do_start(4'd2);
        put(4'd3, 4'd3);
        tick();
        put(4'd2, 4'd2);
        tick();
        chk("bp_res_valid", int'(res_valid), 1);
        start = 1'b1; len = 4'd5;
        repeat (5) tick();
        chk("bp_still_done", int'(res_valid), 1);
        chk("bp_no_handshake", done_n, 0);
        res_ready = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("bp_exit_busy", int'(busy), 0);
        chk("bp_exit_res_valid", int'(res_valid), 0);
        @(negedge clk);
        chk("bp_start_ignored", int'(busy), 0);
        chk("bp_en_cycles", en_n, 2);
        chk("bp_clr_cycles", clr_n, 1);
        tick();

        // Async reset mid-RUN after two accepts, then a fresh job of 7*7 = 49
        do_start(4'd4);
        put(4'd1, 4'd2); put(4'd3, 4'd4);
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        #2 rst = 1'b0;
        in_valid = 1'b0;
        tick();
        exp_q.push_back({1'b0, 9'd49});
        do_start(4'd1);
        put(4'd7, 4'd7);
        wait_idle();

`ifdef STALL_TIMEOUT_EN
        exp_q.push_back({1'b1, 9'd16});
        do_start(4'd3);
        put(4'd4, 4'd4);
        wait_idle();
        chk("to_flag_cleared", int'(timeout), 0);
`else
        do_start(4'd3);
        put(4'd4, 4'd4);
        repeat (100) tick();
        chk("stall_in_run", int'(in_ready), 1);
        chk("stall_no_result", int'(res_valid), 0);
        chk("stall_timeout", int'(timeout), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
